// File: rtl/mux2x1_arb_pkg.sv
// rtl/mux2x1_arb_pkg.sv - shared state encoding and hold-counter width for mux2x1_arbiter
package mux2x1_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int CNT_W = 8;

endpackage

// File: rtl/mux2x1_cmos.sv
// rtl/mux2x1_cmos.sv - single-bit 2:1 mux cell, s = 0 selects a0
module mux2x1_cmos (
  output logic y,
  input  logic s,
  input  logic a0,
  input  logic a1
);

  assign y = s ? a1 : a0;

endmodule

// File: rtl/mux2x1_arbiter.sv
// rtl/mux2x1_arbiter.sv - two-requester round-robin arbiter driving a W-bit mux of mux2x1_cmos cells
// Optional forced handoff after HOLD_MAX grant cycles: MUX2X1_ARB_TIMEOUT_EN
module mux2x1_arbiter
  import mux2x1_arb_pkg::*;
#(
  parameter int W        = 8,
  parameter int HOLD_MAX = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] a1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         s,
  output logic         busy,
  output logic [W-1:0] y
);

  arb_state_t state, state_nxt;
  logic       last, last_nxt;
  logic       s_nxt;
  logic       preempt;

`ifdef MUX2X1_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] hold_cnt;

  // Counter restarts on every new owner and sits at zero while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if ((state_nxt != state) || (state_nxt == IDLE)) begin
      hold_cnt <= '0;
    end else if (!(&hold_cnt)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign preempt = (hold_cnt >= HOLD_LIM);
`else
  logic unused_hold_max;

  assign unused_hold_max = ^HOLD_MAX;
  assign preempt         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      s     <= 1'b0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      s     <= s_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && req1)  state_nxt = last ? OWN0 : OWN1;
        else if (req0)     state_nxt = OWN0;
        else if (req1)     state_nxt = OWN1;
      end
      OWN0: begin
        if (req0 && !(req1 && preempt)) state_nxt = OWN0;
        else if (req1)                  state_nxt = OWN1;
        else                            state_nxt = IDLE;
      end
      OWN1: begin
        if (req1 && !(req0 && preempt)) state_nxt = OWN1;
        else if (req0)                  state_nxt = OWN0;
        else                            state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Select and round-robin pointer follow the owner; both hold through IDLE.
    last_nxt = last;
    s_nxt    = s;
    if (state_nxt == OWN0) begin
      last_nxt = 1'b0;
      s_nxt    = 1'b0;
    end else if (state_nxt == OWN1) begin
      last_nxt = 1'b1;
      s_nxt    = 1'b1;
    end
  end

  assign gnt0 = (state == OWN0);
  assign gnt1 = (state == OWN1);
  assign busy = gnt0 | gnt1;

  for (genvar i = 0; i < W; i++) begin : g_bit
    mux2x1_cmos u_mux (
      .y  (y[i]),
      .s  (s),
      .a0 (a0[i]),
      .a1 (a1[i])
    );
  end

endmodule

// File: tb/tb_mux2x1_arbiter.sv
// tb/tb_mux2x1_arbiter.sv - self-checking bench for mux2x1_arbiter with an owner-level reference model
module tb_mux2x1_arbiter;

  localparam int W        = 8;
  localparam int HOLD_MAX = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0  = 1'b0;
  logic         req1  = 1'b0;
  logic [W-1:0] a0    = 8'hA5;
  logic [W-1:0] a1    = 8'h3C;
  logic         gnt0, gnt1, s, busy;
  logic [W-1:0] y;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  mux2x1_arbiter #(.W(W), .HOLD_MAX(HOLD_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (req0),
    .req1  (req1),
    .a0    (a0),
    .a1    (a1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .s     (s),
    .busy  (busy),
    .y     (y)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: owner is -1 (nobody), 0 or 1; held counts cycles the owner has had the path.
  int owner  = -1;
  bit m_last = 1'b1;
  bit m_sel  = 1'b0;
  int held   = 0;

  always @(posedge clk or negedge rst_n) begin
    logic [1:0] r;
    int         nxt;
    if (!rst_n) begin
      owner  = -1;
      m_last = 1'b1;
      m_sel  = 1'b0;
      held   = 0;
    end else begin
      r = {req1, req0};
      if (owner < 0) begin
        if (r == 2'b11)   nxt = m_last ? 0 : 1;
        else if (r[0])    nxt = 0;
        else if (r[1])    nxt = 1;
        else              nxt = -1;
      end else if (r[owner]) begin
        nxt = owner;
`ifdef MUX2X1_ARB_TIMEOUT_EN
        if (held >= HOLD_MAX && r[1-owner]) nxt = 1 - owner;
`endif
      end else if (r[1-owner]) begin
        nxt = 1 - owner;
      end else begin
        nxt = -1;
      end
      if (nxt != owner) held = (nxt >= 0) ? 1 : 0;
      else if (nxt >= 0) held = held + 1;
      if (nxt >= 0) begin
        m_last = (nxt == 1);
        m_sel  = (nxt == 1);
      end
      owner = nxt;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_gnt0", 32'(gnt0), 32'(owner == 0));
      check("m_gnt1", 32'(gnt1), 32'(owner == 1));
      check("m_s",    32'(s),    32'(m_sel));
      check("m_busy", 32'(busy), 32'(owner >= 0));
      check("m_y",    32'(y),    32'(m_sel ? a1 : a0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hold_cycles;
    bit saw_gnt1;

    tick();
    tick();
    cmp_en = 1'b1;
    check("rst_gnt0", 32'(gnt0), 32'd0);
    check("rst_gnt1", 32'(gnt1), 32'd0);
    check("rst_s",    32'(s),    32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_y",    32'(y),    32'hA5);
    rst_n = 1'b1;
    tick();

    // Single requester 0.
    req0 = 1'b1;
    tick();
    check("r0_gnt0", 32'(gnt0), 32'd1);
    check("r0_s",    32'(s),    32'd0);
    check("r0_y",    32'(y),    32'hA5);
    check("r0_busy", 32'(busy), 32'd1);
    req0 = 1'b0;
    tick();
    check("r0_rel_busy", 32'(busy), 32'd0);

    // Tie straight out of reset goes to requester 0, then direct handoff.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    req0 = 1'b1;
    req1 = 1'b1;
    tick();
    check("tie_gnt0", 32'(gnt0), 32'd1);
    check("tie_gnt1", 32'(gnt1), 32'd0);
    req0 = 1'b0;
    tick();
    check("ho_gnt0", 32'(gnt0), 32'd0);
    check("ho_gnt1", 32'(gnt1), 32'd1);
    check("ho_s",    32'(s),    32'd1);
    check("ho_y",    32'(y),    32'h3C);
    req1 = 1'b0;
    tick();
    check("idle_s_hold", 32'(s), 32'd1);

    // Repeated ties alternate, starting with 0 since 1 owned last.
    for (int k = 0; k < 4; k++) begin
      req0 = 1'b1;
      req1 = 1'b1;
      tick();
      check("alt_gnt0", 32'(gnt0), 32'(k % 2 == 0));
      check("alt_gnt1", 32'(gnt1), 32'(k % 2 == 1));
      tick();
      req0 = 1'b0;
      req1 = 1'b0;
      tick();
    end

    // One-cycle req1 pulse while 0 owns: never granted.
    req0 = 1'b1;
    tick();
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    tick();
    check("pulse_gnt1_a", 32'(gnt1), 32'd0);
    tick();
    check("pulse_gnt1_b", 32'(gnt1), 32'd0);
    check("pulse_gnt0",   32'(gnt0), 32'd1);
    req0 = 1'b0;
    tick();

    // Asynchronous reset mid-OWN1 drops everything before the next edge.
    req1 = 1'b1;
    tick();
    check("ar_pre_gnt1", 32'(gnt1), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_gnt1", 32'(gnt1), 32'd0);
    check("ar_s",    32'(s),    32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    req1  = 1'b0;
    tick();
    tick();

    // Long hold with a competing request.
    req0 = 1'b1;
    tick();
    req1 = 1'b1;
    hold_cycles = 1;
    saw_gnt1 = 1'b0;
`ifdef MUX2X1_ARB_TIMEOUT_EN
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gnt0) hold_cycles++;
      else break;
    end
    check("to_hold_cycles", 32'(hold_cycles), 32'd4);
    check("to_gnt1",        32'(gnt1),        32'd1);
`else
    for (int i = 0; i < 19; i++) begin
      tick();
      if (gnt0) hold_cycles++;
      if (gnt1) saw_gnt1 = 1'b1;
    end
    check("hold_cycles", 32'(hold_cycles), 32'd20);
    check("hold_no_gnt1", 32'(saw_gnt1), 32'd0);
`endif
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();

    // Randomized traffic against the model, with occasional async reset pulses.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) req0 = ~req0;
      if ($urandom_range(0, 3) == 0) req1 = ~req1;
      a0 = W'($urandom);
      a1 = W'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("rnd_ar_busy", 32'(busy), 32'd0);
        check("rnd_ar_s",    32'(s),    32'd0);
        rst_n = 1'b1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
